// File: rtl/utmi_receiver_pkg.sv
// utmi_receiver_pkg: state encodings and default SYNC shared by the UTMI receive and transmit paths
package utmi_receiver_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HUNT  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STRIP = 3'd3;
  localparam logic [2:0] ST_EOP   = 3'd4;
  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;
endpackage

// File: rtl/utmi_nrzi_dec.sv
// utmi_nrzi_dec: NRZI line decoder with previous-level register and bypass
module utmi_nrzi_dec (
  input  logic clk,
  input  logic rst,
  input  logic nrzi_en,
  input  logic rx_serial,
  input  logic se0,
  input  logic eop_done,
  output logic dec
);
  logic prev_line;
  always_ff @(posedge clk)
    if (rst || eop_done) prev_line <= 1'b1;
    else if (!se0) prev_line <= rx_serial;
  always_comb dec = nrzi_en ? ~(rx_serial ^ prev_line) : rx_serial;
endmodule

// File: rtl/utmi_receiver.sv
// utmi_receiver: UTMI receive path with NRZI decode, SYNC hunt, bit unstuffing and EOP detection
module utmi_receiver
  import utmi_receiver_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = SYNC_DEFAULT,
  parameter int         STUFF_RUN    = 6,
  parameter int         EOP_LEN      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       nrzi_en,
  input  logic       unstuff_en,
  input  logic       rx_serial,
  input  logic       se0,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       sync_found,
  output logic       rx_error
);
  logic [2:0] state;
  logic [7:0] window, shift, win_nx, shift_nx;
  logic [2:0] bit_cnt, ones_cnt, ones_nx;
  logic [1:0] se0_cnt;
  logic       dec, eop_hit;
  utmi_nrzi_dec u_dec (
    .clk(clk), .rst(rst), .nrzi_en(nrzi_en), .rx_serial(rx_serial),
    .se0(se0), .eop_done(eop_hit), .dec(dec)
  );
  always_comb begin
    win_nx = {dec, window[7:1]};
    shift_nx = shift;
    shift_nx[bit_cnt] = dec;
    ones_nx = dec ? (ones_cnt == 3'd7 ? ones_cnt : ones_cnt + 3'd1) : 3'd0;
    eop_hit = rx_en && se0 && (state == ST_DATA || state == ST_STRIP) && se0_cnt == 2'(EOP_LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      window <= '0;
      shift <= '0;
      bit_cnt <= '0;
      ones_cnt <= '0;
      se0_cnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_active <= 1'b0;
      sync_found <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      sync_found <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_en) begin
        state <= ST_IDLE;
        rx_active <= 1'b0;
        window <= '0;
        bit_cnt <= '0;
        ones_cnt <= '0;
        se0_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_HUNT;
          ST_HUNT: if (!se0) begin
            window <= win_nx == SYNC_PATTERN ? 8'd0 : win_nx;
            if (win_nx == SYNC_PATTERN) begin
              sync_found <= 1'b1;
              rx_active <= 1'b1;
              bit_cnt <= '0;
              ones_cnt <= '0;
              se0_cnt <= '0;
              state <= ST_DATA;
            end
          end
          ST_DATA, ST_STRIP: if (se0) begin
            se0_cnt <= eop_hit ? 2'd0 : se0_cnt + 2'd1;
            if (eop_hit) begin
              state <= ST_EOP;
              rx_active <= 1'b0;
              rx_error <= bit_cnt != 3'd0;
              bit_cnt <= '0;
              ones_cnt <= '0;
            end
          end else if (state == ST_STRIP) begin
            // stuffed bit: a 0 is dropped, a 1 breaks the packet
            se0_cnt <= '0;
            ones_cnt <= '0;
            state <= dec ? ST_HUNT : ST_DATA;
            rx_error <= dec;
            rx_active <= ~dec;
            bit_cnt <= dec ? 3'd0 : bit_cnt;
          end else begin
            se0_cnt <= '0;
            shift <= shift_nx;
            bit_cnt <= bit_cnt + 3'd1;
            ones_cnt <= ones_nx;
            rx_valid <= bit_cnt == 3'd7;
            rx_data <= bit_cnt == 3'd7 ? shift_nx : rx_data;
            state <= unstuff_en && ones_nx == 3'(STUFF_RUN) ? ST_STRIP : ST_DATA;
          end
          ST_EOP: state <= se0 ? ST_EOP : ST_HUNT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
